// File: rtl/gray_seq_checker.sv
// -----------------------------------------------------------------------------
// gray_seq_checker
//
// Consumer-side watchdog for a 3-bit Gray counter. On every accepted sample
// (rising Clk with En=1 and Clr=0) it converts the incoming Gray code to
// binary and checks the sample against the one before it. The sample must be
// the single-step successor in Gray order, and the Overflow flag must stay
// consistent with the wraps already seen. It reports the number of wraps, a
// sticky error flag and a saturating error count.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-high reset, clears all state
//   En        in   sample strobe (shared with the upstream counter)
//   Clr       in   synchronous status clear, overrides En
//   Gray[2:0] in   Gray code from the upstream counter
//   Overflow  in   upstream sticky overflow flag
//   Bin[2:0]  out  binary value of the last accepted sample
//   Valid     out  Bin holds a sampled value
//   WrapCnt   out  saturating count of legal 100->000 wraps
//   Error     out  sticky sequence/flag error
//   ErrCnt    out  saturating count of errors
//   State     out  FSM state: IDLE=00, LOCK=01, FAULT=10
// -----------------------------------------------------------------------------
module gray_seq_checker #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Clr,
    input  logic [2:0]        Gray,
    input  logic              Overflow,
    output logic [2:0]        Bin,
    output logic              Valid,
    output logic [WRAP_W-1:0] WrapCnt,
    output logic              Error,
    output logic [ERR_W-1:0]  ErrCnt,
    output logic [1:0]        State
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOCK  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          bin_q, bin_d;
    logic                valid_q, valid_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic                error_q, error_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [2:0]          prev_q, prev_d;
    logic                seen_wrap_q, seen_wrap_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above it. Applied to both the incoming sample and the stored one.
    logic [2:0] cur_bin;
    logic [2:0] prev_bin;

    for (genvar gi = 0; gi < 3; gi++) begin : g_gray2bin
        assign cur_bin[gi]  = ^Gray[2:gi];
        assign prev_bin[gi] = ^prev_q[2:gi];
    end

    // Sample classification. The legal successor in Gray order is exactly
    // the sample whose binary value is one more than the previous one, so the
    // step check is done in the binary domain.
    logic is_resync;
    logic is_wrap;
    logic is_step;
    logic wrap_sat;
    logic err_sat;

    always_comb begin
        is_resync = (Gray == 3'b000) && !Overflow;
        is_wrap   = (Gray == 3'b000) && Overflow && (prev_q == 3'b100);
        is_step   = (Gray != 3'b000)
                    && (cur_bin == 3'(prev_bin + 3'd1))
                    && (Overflow == seen_wrap_q);
        wrap_sat  = (wrap_cnt_q == {WRAP_W{1'b1}});
        err_sat   = (err_cnt_q == {ERR_W{1'b1}});
    end

    // Next-state / datapath logic.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        valid_d     = valid_q;
        wrap_cnt_d  = wrap_cnt_q;
        error_d     = error_q;
        err_cnt_d   = err_cnt_q;
        prev_d      = prev_q;
        seen_wrap_d = seen_wrap_q;

        if (Clr) begin
            // Status clear; Bin and prev are deliberately left alone, and the
            // sample offered on this edge (if any) is dropped.
            wrap_cnt_d  = '0;
            error_d     = 1'b0;
            err_cnt_d   = '0;
            valid_d     = 1'b0;
            state_d     = ST_IDLE;
            seen_wrap_d = 1'b0;
        end else if (En) begin
            bin_d  = cur_bin;
            prev_d = Gray;

            if (state_q == ST_IDLE) begin
                // First sample only establishes the reference point.
                seen_wrap_d = Overflow;
                valid_d     = 1'b1;
                state_d     = ST_LOCK;
            end else if (is_resync) begin
                // Upstream counter was reset: start over without complaint.
                seen_wrap_d = 1'b0;
                state_d     = ST_LOCK;
            end else if (is_wrap) begin
                if (!wrap_sat) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                end
                seen_wrap_d = 1'b1;
            end else if (!is_step) begin
                // Any other sample is a sequence or flag error. Tracking
                // re-anchors on the bad sample so one glitch is one error.
                error_d = 1'b1;
                if (!err_sat) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                state_d     = ST_FAULT;
                seen_wrap_d = Overflow;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            valid_q     <= 1'b0;
            wrap_cnt_q  <= '0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            prev_q      <= '0;
            seen_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            valid_q     <= valid_d;
            wrap_cnt_q  <= wrap_cnt_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
            prev_q      <= prev_d;
            seen_wrap_q <= seen_wrap_d;
        end
    end

    assign Bin     = bin_q;
    assign Valid   = valid_q;
    assign WrapCnt = wrap_cnt_q;
    assign Error   = error_q;
    assign ErrCnt  = err_cnt_q;
    assign State   = state_q;

endmodule
